bufferram_arbiter: RTL and testbench
====================================

# bufferram_arbiter

Two-requester arbiter and sequencer for the on-chip frame buffer RAM slave exported from the Qsys system (17-bit word address, 16-bit data, 2-bit byte enable). Sits in the top level between the producer (pixel writer, port A) and consumer (display/readout engine, port B) and drives the `bufferram_out_*` conduit. Grants round-robin with bounded bursts, registers every RAM command, and routes read data back to the issuing port via a latency-matched tag pipeline.

## Interface
- `ADDR_W`, 17, RAM word-address width
- `DATA_W`, 16, RAM data width; byte-enable width is `DATA_W/8`
- `READ_LATENCY`, 1, cycles from command on RAM bus to valid `ram_readdata` (1 or 2)
- `MAX_BURST`, 8, max consecutive accepts per grant while the other port waits (≥1)
- `clk_clk`  in  1  single clock; RAM conduit runs on the same clock
- `reset_reset_n`  in  1  asynchronous, active-low reset
- `a_req`, `b_req`  in  1  request valid
- `a_ready`, `b_ready`  out  1  request accepted this cycle when `req && ready`
- `a_write`, `b_write`  in  1  1 = write, 0 = read
- `a_addr`, `b_addr`  in  ADDR_W  word address
- `a_wdata`, `b_wdata`  in  DATA_W  write data
- `a_be`, `b_be`  in  DATA_W/8  byte enables
- `a_rvalid`, `b_rvalid`  out  1  one-cycle read-data strobe
- `a_rdata`, `b_rdata`  out  DATA_W  read data, valid with `rvalid`
- `ram_address`  out  ADDR_W  to `bufferram_out_address`
- `ram_chipselect`  out  1  to `bufferram_out_chipselect`
- `ram_clken`  out  1  to `bufferram_out_clken`
- `ram_write`  out  1  to `bufferram_out_write`
- `ram_writedata`  out  DATA_W  to `bufferram_out_writedata`
- `ram_byteenable`  out  DATA_W/8  to `bufferram_out_byteenable`
- `ram_readdata`  in  DATA_W  from `bufferram_out_readdata`

## Operation
- FSM states IDLE, GRANT_A, GRANT_B; `a_ready = (state==GRANT_A)`, `b_ready = (state==GRANT_B)`, decoded from registered state only.
- `last` flag records the most recently granted port; reset value = B, so A wins the first tie.
- IDLE: both req → grant the port ≠ `last`; one req → grant it; none → stay.
- GRANT_X: X req low → go to other port if its req is high, else IDLE. X accepted and `burst_cnt == MAX_BURST-1` and other req high → switch to other. Otherwise stay.
- `burst_cnt` (width clog2(MAX_BURST), min 1) clears on entering any grant state; increments per accept; saturates at MAX_BURST-1 while other port idle (never wraps).
- On each accept, the RAM command registers load addr/wdata/be/write; `ram_chipselect`=1 for exactly that one following cycle, 0 otherwise (`ram_write` also 0 when idle).
- `ram_clken` = 1 constantly after reset.
- Read accept pushes tag {valid, port} into a shift pipe of depth 1+READ_LATENCY; on exit, pulse matching `rvalid`, drive `rdata` = `ram_readdata`. Writes push valid=0 tags.
- `a_rdata`/`b_rdata` hold the last returned value between strobes.

## Timing
- Reset (async assert, sync-released use): state IDLE, `last`=B, `burst_cnt`=0, all tags invalid; all outputs 0 except `ram_clken`=0 during reset, 1 from first clock after release.
- Accept at cycle N → RAM command visible in cycle N+1 → `rvalid` in cycle N+1+READ_LATENCY.
- Full throughput: one accept per cycle while a grant holds and req stays high.
- Grant switch costs one dead cycle when current holder drops req (state decided from prior cycle); burst-limit switch costs none (next cycle already granted to other).
- Reads and writes from both ports may interleave back-to-back; responses return in issue order, never out of order.
- Reset mid-operation: in-flight reads discarded, no `rvalid` emitted after reset release for pre-reset reads.

## Test plan
- Reset: hold `reset_reset_n`=0 with both reqs high → all readys, rvalids, chipselect, write = 0; release → `a_ready`=1 first cycle.
- Single A write addr 0x1FFFF data 0xBEEF be 2'b11, then A read same addr (READ_LATENCY=1) → chipselect pulses at N+1 and N+2 (write, read), `a_rvalid`=1 with 0xBEEF at cycle N+3 after read accept at N+1.
- Both ports request continuously, MAX_BURST=8 → grants alternate exactly 8 A accepts, 8 B accepts, no idle cycles between bursts.
- Only A requests for 20 cycles → 20 consecutive accepts, `burst_cnt` saturates at 7, no switch.
- Interleaved reads A,B,A back-to-back with READ_LATENCY=2 → rvalids on A,B,A in consecutive cycles with correct data each.
- Assert reset one cycle after a read accept → no rvalid ever issued for that read.

Source files
------------

// File: rtl/bufferram_arbiter.sv
// bufferram_arbiter: round-robin arbiter/sequencer for two requesters sharing the frame buffer RAM.
// Ports: clk_clk/reset_reset_n; per-port a_*/b_* req/ready/write/addr/wdata/be and rvalid/rdata;
//        ram_* drives the bufferram_out conduit (registered command, read data returned via tag pipe).
module bufferram_arbiter #(
  parameter int ADDR_W       = 17,
  parameter int DATA_W       = 16,
  parameter int READ_LATENCY = 1,
  parameter int MAX_BURST    = 8
) (
  input  logic                  clk_clk,
  input  logic                  reset_reset_n,
  // port A (producer)
  input  logic                  a_req,
  output logic                  a_ready,
  input  logic                  a_write,
  input  logic [ADDR_W-1:0]     a_addr,
  input  logic [DATA_W-1:0]     a_wdata,
  input  logic [DATA_W/8-1:0]   a_be,
  output logic                  a_rvalid,
  output logic [DATA_W-1:0]     a_rdata,
  // port B (consumer)
  input  logic                  b_req,
  output logic                  b_ready,
  input  logic                  b_write,
  input  logic [ADDR_W-1:0]     b_addr,
  input  logic [DATA_W-1:0]     b_wdata,
  input  logic [DATA_W/8-1:0]   b_be,
  output logic                  b_rvalid,
  output logic [DATA_W-1:0]     b_rdata,
  // RAM conduit
  output logic [ADDR_W-1:0]     ram_address,
  output logic                  ram_chipselect,
  output logic                  ram_clken,
  output logic                  ram_write,
  output logic [DATA_W-1:0]     ram_writedata,
  output logic [DATA_W/8-1:0]   ram_byteenable,
  input  logic [DATA_W-1:0]     ram_readdata
);

  localparam int CNT_W  = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam int PIPE_D = 1 + READ_LATENCY;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST - 1);

  typedef enum logic [1:0] {IDLE, GRANT_A, GRANT_B} state_t;

  state_t           state;
  logic             last_b;     // 1: B was the most recent grant, so A wins the next tie
  logic [CNT_W-1:0] burst_cnt;

  logic a_acc, b_acc, cmd_write;

  // Readies decode registered state only; no combinational path from req to ready.
  assign a_ready   = (state == GRANT_A);
  assign b_ready   = (state == GRANT_B);
  assign a_acc     = a_req & a_ready;
  assign b_acc     = b_req & b_ready;
  assign cmd_write = a_acc ? a_write : b_write;

  // Arbitration FSM. The burst counter only matters while the other port is waiting;
  // it saturates instead of wrapping so a lone requester keeps the grant indefinitely.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state     <= IDLE;
      last_b    <= 1'b1;
      burst_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (a_req && (!b_req || last_b)) begin
            state     <= GRANT_A;
            last_b    <= 1'b0;
            burst_cnt <= '0;
          end else if (b_req) begin
            state     <= GRANT_B;
            last_b    <= 1'b1;
            burst_cnt <= '0;
          end
        end
        GRANT_A: begin
          if (!a_req) begin
            if (b_req) begin
              state     <= GRANT_B;
              last_b    <= 1'b1;
              burst_cnt <= '0;
            end else begin
              state <= IDLE;
            end
          end else if (burst_cnt == CNT_MAX && b_req) begin
            state     <= GRANT_B;
            last_b    <= 1'b1;
            burst_cnt <= '0;
          end else if (burst_cnt != CNT_MAX) begin
            burst_cnt <= burst_cnt + 1'b1;
          end
        end
        GRANT_B: begin
          if (!b_req) begin
            if (a_req) begin
              state     <= GRANT_A;
              last_b    <= 1'b0;
              burst_cnt <= '0;
            end else begin
              state <= IDLE;
            end
          end else if (burst_cnt == CNT_MAX && a_req) begin
            state     <= GRANT_A;
            last_b    <= 1'b0;
            burst_cnt <= '0;
          end else if (burst_cnt != CNT_MAX) begin
            burst_cnt <= burst_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // RAM command register: every accept becomes exactly one chipselect cycle.
  // Address/data/be hold their last value when idle; write drops to 0.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      ram_address    <= '0;
      ram_writedata  <= '0;
      ram_byteenable <= '0;
      ram_write      <= 1'b0;
      ram_chipselect <= 1'b0;
      ram_clken      <= 1'b0;
    end else begin
      ram_clken      <= 1'b1;
      ram_chipselect <= a_acc | b_acc;
      if (a_acc) begin
        ram_address    <= a_addr;
        ram_writedata  <= a_wdata;
        ram_byteenable <= a_be;
        ram_write      <= a_write;
      end else if (b_acc) begin
        ram_address    <= b_addr;
        ram_writedata  <= b_wdata;
        ram_byteenable <= b_be;
        ram_write      <= b_write;
      end else begin
        ram_write <= 1'b0;
      end
    end
  end

  // Tag pipe: one slot per cycle from accept to data return, so a tag reaches the
  // last stage exactly when its read data is on ram_readdata. Order is preserved
  // by construction. Reset drops all in-flight tags.
  logic [PIPE_D-1:0] tag_vld;
  logic [PIPE_D-1:0] tag_port;  // 1 = B

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      tag_vld  <= '0;
      tag_port <= '0;
    end else begin
      tag_vld  <= {tag_vld[PIPE_D-2:0], (a_acc | b_acc) & ~cmd_write};
      tag_port <= {tag_port[PIPE_D-2:0], b_acc};
    end
  end

  assign a_rvalid = tag_vld[PIPE_D-1] & ~tag_port[PIPE_D-1];
  assign b_rvalid = tag_vld[PIPE_D-1] &  tag_port[PIPE_D-1];

  // Read data passes straight through on the strobe and is held afterwards.
  logic [DATA_W-1:0] a_rdata_q, b_rdata_q;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      if (a_rvalid) a_rdata_q <= ram_readdata;
      if (b_rvalid) b_rdata_q <= ram_readdata;
    end
  end

  assign a_rdata = a_rvalid ? ram_readdata : a_rdata_q;
  assign b_rdata = b_rvalid ? ram_readdata : b_rdata_q;

endmodule

// File: tb/tb_bufferram_arbiter.sv
// tb_bufferram_arbiter: randomized + directed stimulus against a queue-based reference model.
// Ports: none; drives bufferram_arbiter, models the RAM, scoreboards commands and read returns.
module tb_bufferram_arbiter;
  localparam int ADDR_W = 17;
  localparam int DATA_W = 16;
  localparam int RL     = 2;
  localparam int MB     = 8;

  logic              clk_clk = 1'b0;
  logic              reset_reset_n = 1'b0;
  logic              a_req = 1'b0, b_req = 1'b0;
  logic              a_ready, b_ready;
  logic              a_write = 1'b0, b_write = 1'b0;
  logic [ADDR_W-1:0] a_addr = '0, b_addr = '0;
  logic [DATA_W-1:0] a_wdata = '0, b_wdata = '0;
  logic [1:0]        a_be = '0, b_be = '0;
  logic              a_rvalid, b_rvalid;
  logic [DATA_W-1:0] a_rdata, b_rdata;
  logic [ADDR_W-1:0] ram_address;
  logic              ram_chipselect, ram_clken, ram_write;
  logic [DATA_W-1:0] ram_writedata;
  logic [1:0]        ram_byteenable;
  logic [DATA_W-1:0] ram_readdata;

  always #5 clk_clk = ~clk_clk;

  bufferram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_LATENCY(RL), .MAX_BURST(MB)) dut (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
    .a_req(a_req), .a_ready(a_ready), .a_write(a_write), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_be(a_be), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_ready(b_ready), .b_write(b_write), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_be(b_be), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .ram_address(ram_address), .ram_chipselect(ram_chipselect), .ram_clken(ram_clken),
    .ram_write(ram_write), .ram_writedata(ram_writedata), .ram_byteenable(ram_byteenable),
    .ram_readdata(ram_readdata)
  );

  typedef struct { bit wr; bit [16:0] addr; bit [15:0] data; bit [1:0] be; } req_t;
  typedef struct { bit wr; bit [16:0] addr; bit [15:0] data; bit [1:0] be; int due; } cmd_t;
  typedef struct { bit port; bit [15:0] data; int due; } rsp_t;

  req_t qa[$], qb[$];
  cmd_t cmdq[$];
  rsp_t rspq[$];
  bit [15:0] ref_mem [bit [16:0]];
  bit [15:0] ram_mem [bit [16:0]];

  int tests = 0, fails = 0, cyc = 0;
  bit a_acc = 1'b0, b_acc = 1'b0;
  bit log_en = 1'b0;
  int acc_port_log[$], acc_cyc_log[$];
  int rv_count = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit [15:0] merge(input bit [15:0] old, input bit [15:0] d, input bit [1:0] be);
    bit [15:0] r;
    r = old;
    if (be[0]) r[7:0]  = d[7:0];
    if (be[1]) r[15:8] = d[15:8];
    return r;
  endfunction

  function automatic req_t mk(input bit wr, input bit [16:0] addr, input bit [15:0] data, input bit [1:0] be);
    req_t r;
    r.wr = wr; r.addr = addr; r.data = data; r.be = be;
    return r;
  endfunction

  function automatic req_t rand_req();
    bit [16:0] ad;
    ad = ($urandom_range(7) == 0) ? 17'h1FFFF : 17'($urandom_range(15));
    return mk(1'($urandom_range(1)), ad, 16'($urandom), 2'($urandom_range(3)));
  endfunction

  // RAM behavioural model: command sampled mid-cycle, read data appears RL cycles later.
  bit [15:0] rd_next = '0;
  bit [15:0] rd_pipe [RL];

  initial begin
    forever begin
      @(negedge clk_clk);
      rd_next = 16'h0;
      if (ram_chipselect === 1'b1) begin
        if (ram_write)
          ram_mem[ram_address] = merge(ram_mem.exists(ram_address) ? ram_mem[ram_address] : 16'h0,
                                       ram_writedata, ram_byteenable);
        else
          rd_next = ram_mem.exists(ram_address) ? ram_mem[ram_address] : 16'h0;
      end
    end
  end

  always @(posedge clk_clk) begin
    rd_pipe[0] <= rd_next;
    for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign ram_readdata = rd_pipe[RL-1];

  // Monitor + reference model. Arbitration is modelled as "who owns the RAM and how many
  // accepts it has had this grant"; a holder yields after MB accepts only if the other waits.
  initial begin : mon
    int owner, last_g, run, nxt, oth;
    bit hr, orq, clken_exp, exp_cs, exp_ra, exp_rb;
    bit [15:0] hold_a, hold_b, rd;
    cmd_t c;
    rsp_t r;
    owner = 0; last_g = 2; run = 0; clken_exp = 0; hold_a = 0; hold_b = 0;
    forever begin
      @(negedge clk_clk);
      cyc++;
      if (!reset_reset_n) begin
        chk("rst_ready", 32'({a_ready, b_ready}), 32'd0);
        chk("rst_rvalid", 32'({a_rvalid, b_rvalid}), 32'd0);
        chk("rst_cs_wr_clken", 32'({ram_chipselect, ram_write, ram_clken}), 32'd0);
        chk("rst_rdata", {a_rdata, b_rdata}, 32'd0);
        cmdq.delete(); rspq.delete();
        owner = 0; last_g = 2; run = 0; clken_exp = 0; hold_a = 0; hold_b = 0;
        a_acc = 0; b_acc = 0;
      end else begin
        chk("ready", 32'({a_ready, b_ready}), 32'({owner == 1, owner == 2}));
        chk("clken", 32'(ram_clken), 32'(clken_exp));
        clken_exp = 1;

        while (cmdq.size() > 0 && cmdq[0].due < cyc) cmdq.delete(0);
        exp_cs = (cmdq.size() > 0) && (cmdq[0].due == cyc);
        chk("chipselect", 32'(ram_chipselect), 32'(exp_cs));
        if (exp_cs) begin
          c = cmdq.pop_front();
          chk("cmd_write", 32'(ram_write), 32'(c.wr));
          chk("cmd_addr", 32'(ram_address), 32'(c.addr));
          chk("cmd_be", 32'(ram_byteenable), 32'(c.be));
          if (c.wr) chk("cmd_wdata", 32'(ram_writedata), 32'(c.data));
        end else begin
          chk("idle_write", 32'(ram_write), 32'd0);
        end

        while (rspq.size() > 0 && rspq[0].due < cyc) rspq.delete(0);
        exp_ra = (rspq.size() > 0) && (rspq[0].due == cyc) && (rspq[0].port == 1'b0);
        exp_rb = (rspq.size() > 0) && (rspq[0].due == cyc) && (rspq[0].port == 1'b1);
        chk("rvalid", 32'({a_rvalid, b_rvalid}), 32'({exp_ra, exp_rb}));
        if (a_rvalid || b_rvalid) rv_count++;
        if (exp_ra || exp_rb) begin
          r = rspq.pop_front();
          if (r.port) hold_b = r.data; else hold_a = r.data;
        end
        chk("a_rdata", 32'(a_rdata), 32'(hold_a));
        chk("b_rdata", 32'(b_rdata), 32'(hold_b));

        a_acc = a_req && a_ready;
        b_acc = b_req && b_ready;
        if (a_acc || b_acc) begin
          c.wr   = a_acc ? a_write : b_write;
          c.addr = a_acc ? a_addr  : b_addr;
          c.data = a_acc ? a_wdata : b_wdata;
          c.be   = a_acc ? a_be    : b_be;
          c.due  = cyc + 1;
          cmdq.push_back(c);
          rd = ref_mem.exists(c.addr) ? ref_mem[c.addr] : 16'h0;
          if (c.wr) begin
            ref_mem[c.addr] = merge(rd, c.data, c.be);
          end else begin
            r.port = b_acc; r.data = rd; r.due = cyc + 1 + RL;
            rspq.push_back(r);
          end
          if (log_en) begin
            acc_port_log.push_back(a_acc ? 1 : 2);
            acc_cyc_log.push_back(cyc);
          end
        end

        if (owner == 0) begin
          if (a_req && b_req) nxt = (last_g == 1) ? 2 : 1;
          else if (a_req)     nxt = 1;
          else if (b_req)     nxt = 2;
          else                nxt = 0;
        end else begin
          oth = 3 - owner;
          hr  = (owner == 1) ? a_req : b_req;
          orq = (owner == 1) ? b_req : a_req;
          if (!hr) nxt = orq ? oth : 0;
          else begin
            run++;
            nxt = (run >= MB && orq) ? oth : owner;
          end
        end
        if (nxt != owner) begin
          owner = nxt;
          if (nxt != 0) begin last_g = nxt; run = 0; end
        end
      end
    end
  end

  // Driver: the head of each port queue is presented until the monitor sees it accepted.
  task automatic step(input bit rnd);
    @(posedge clk_clk);
    #1;
    if (a_acc && qa.size() > 0) qa.delete(0);
    if (b_acc && qb.size() > 0) qb.delete(0);
    a_req = (qa.size() > 0) && !(rnd && $urandom_range(3) == 0);
    b_req = (qb.size() > 0) && !(rnd && $urandom_range(3) == 0);
    if (qa.size() > 0) begin
      a_write = qa[0].wr; a_addr = qa[0].addr; a_wdata = qa[0].data; a_be = qa[0].be;
    end else begin
      a_write = 0; a_addr = '0; a_wdata = '0; a_be = '0;
    end
    if (qb.size() > 0) begin
      b_write = qb[0].wr; b_addr = qb[0].addr; b_wdata = qb[0].data; b_be = qb[0].be;
    end else begin
      b_write = 0; b_addr = '0; b_wdata = '0; b_be = '0;
    end
  endtask

  task automatic drain(input bit rnd, input int budget);
    int n;
    n = 0;
    while ((qa.size() > 0 || qb.size() > 0) && n < budget) begin
      step(rnd);
      n++;
    end
    chk("drain_timeout", 32'(qa.size() + qb.size()), 32'd0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0);
  endtask

  initial begin : drv
    int bad, gaps, rv_before, n;

    // Reset with both ports requesting; A must win first after release.
    for (int i = 0; i < 4; i++) begin
      qa.push_back(rand_req());
      qb.push_back(rand_req());
    end
    for (int i = 0; i < 4; i++) step(1'b0);
    reset_reset_n = 1'b1;
    drain(1'b0, 200);
    idle(6);

    // Write 0xBEEF to top address, read it back on A.
    qa.push_back(mk(1'b1, 17'h1FFFF, 16'hBEEF, 2'b11));
    qa.push_back(mk(1'b0, 17'h1FFFF, 16'h0000, 2'b11));
    drain(1'b0, 50);
    idle(6);
    chk("beef_readback", 32'(a_rdata), 32'h0000BEEF);

    // Both ports saturated: strict 8/8 alternation, B first because A was last, no gaps.
    acc_port_log.delete(); acc_cyc_log.delete();
    log_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      qa.push_back(rand_req());
      qb.push_back(rand_req());
    end
    drain(1'b0, 300);
    idle(4);
    log_en = 1'b0;
    chk("burst_total", 32'(acc_port_log.size()), 32'd80);
    bad = 0; gaps = 0;
    for (int i = 0; i < acc_port_log.size(); i++) begin
      if (acc_port_log[i] != (((i / MB) % 2 == 0) ? 2 : 1)) bad++;
      if (i > 0 && acc_cyc_log[i] != acc_cyc_log[i-1] + 1) gaps++;
    end
    chk("burst_pattern_errors", 32'(bad), 32'd0);
    chk("burst_gaps", 32'(gaps), 32'd0);

    // Lone requester: 20 back-to-back accepts, never yields.
    acc_port_log.delete(); acc_cyc_log.delete();
    log_en = 1'b1;
    for (int i = 0; i < 20; i++) qa.push_back(rand_req());
    drain(1'b0, 100);
    idle(4);
    log_en = 1'b0;
    chk("solo_count", 32'(acc_port_log.size()), 32'd20);
    gaps = 0;
    for (int i = 1; i < acc_cyc_log.size(); i++)
      if (acc_cyc_log[i] != acc_cyc_log[i-1] + 1) gaps++;
    chk("solo_gaps", 32'(gaps), 32'd0);

    // Interleaved reads from both ports after distinct writes.
    qa.push_back(mk(1'b1, 17'h20, 16'h1111, 2'b11));
    qb.push_back(mk(1'b1, 17'h21, 16'h2222, 2'b11));
    qa.push_back(mk(1'b0, 17'h21, 16'h0, 2'b11));
    qb.push_back(mk(1'b0, 17'h20, 16'h0, 2'b11));
    qa.push_back(mk(1'b0, 17'h20, 16'h0, 2'b11));
    drain(1'b0, 100);
    idle(8);

    // Reset one cycle after a read accept: that read must never return.
    qa.push_back(mk(1'b0, 17'h20, 16'h0, 2'b11));
    n = 0;
    while (qa.size() > 0 && n < 20) begin
      step(1'b0);
      n++;
    end
    chk("mid_reset_accept", 32'(qa.size()), 32'd0);
    reset_reset_n = 1'b0;
    qa.delete(); qb.delete();
    idle(3);
    reset_reset_n = 1'b1;
    rv_before = rv_count;
    idle(12);
    chk("rvalid_after_reset", 32'(rv_count - rv_before), 32'd0);

    // Random mixed traffic with random request gaps.
    for (int i = 0; i < 150; i++) begin
      qa.push_back(rand_req());
      qb.push_back(rand_req());
    end
    drain(1'b1, 5000);
    idle(10);
    chk("cmdq_empty", 32'(cmdq.size()), 32'd0);
    chk("rspq_empty", 32'(rspq.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
